// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the pipeline control slice.
//   regbits_t          : 5-bit architectural register index
//   pipe_ctrl_state_t  : pipeline controller FSM state
//   pipe_ctrl_t        : bundle of PC / pipeline-register enable and flush lines
//   CTRL_*             : canned control bundles for each pipeline action
//   flush_event()      : true when a front-end register is really being flushed
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MEMWAIT = 2'd1,
      HALTED  = 2'd2
   } pipe_ctrl_state_t;

   typedef struct packed {
      logic pc_enable;
      logic ifid_enable;
      logic ifid_flush;
      logic idex_enable;
      logic idex_flush;
      logic exmem_enable;
      logic exmem_flush;
      logic memwb_enable;
      logic memwb_flush;
   } pipe_ctrl_t;

   // Everything advances, nothing flushed.
   localparam pipe_ctrl_t CTRL_ADVANCE = '{
      pc_enable: 1'b1, ifid_enable: 1'b1, ifid_flush: 1'b0,
      idex_enable: 1'b1, idex_flush: 1'b0, exmem_enable: 1'b1,
      exmem_flush: 1'b0, memwb_enable: 1'b1, memwb_flush: 1'b0};

   // Data access outstanding: freeze PC..EX/MEM, push a bubble into MEM/WB.
   localparam pipe_ctrl_t CTRL_MEMSTALL = '{
      pc_enable: 1'b0, ifid_enable: 1'b0, ifid_flush: 1'b0,
      idex_enable: 1'b0, idex_flush: 1'b0, exmem_enable: 1'b0,
      exmem_flush: 1'b0, memwb_enable: 1'b1, memwb_flush: 1'b1};

   // Taken branch: squash the two younger instructions, redirect PC.
   localparam pipe_ctrl_t CTRL_BRANCH = '{
      pc_enable: 1'b1, ifid_enable: 1'b1, ifid_flush: 1'b1,
      idex_enable: 1'b1, idex_flush: 1'b1, exmem_enable: 1'b1,
      exmem_flush: 1'b0, memwb_enable: 1'b1, memwb_flush: 1'b0};

   // Load-use: hold PC and IF/ID, bubble into ID/EX.
   localparam pipe_ctrl_t CTRL_LOADUSE = '{
      pc_enable: 1'b0, ifid_enable: 1'b0, ifid_flush: 1'b0,
      idex_enable: 1'b1, idex_flush: 1'b1, exmem_enable: 1'b1,
      exmem_flush: 1'b0, memwb_enable: 1'b1, memwb_flush: 1'b0};

   // Jump decoded in ID: redirect PC, squash the fall-through fetch.
   localparam pipe_ctrl_t CTRL_JUMP = '{
      pc_enable: 1'b1, ifid_enable: 1'b1, ifid_flush: 1'b1,
      idex_enable: 1'b1, idex_flush: 1'b0, exmem_enable: 1'b1,
      exmem_flush: 1'b0, memwb_enable: 1'b1, memwb_flush: 1'b0};

   // Fetch not back yet: hold PC, bubble into IF/ID, drain the rest.
   localparam pipe_ctrl_t CTRL_NOFETCH = '{
      pc_enable: 1'b0, ifid_enable: 1'b1, ifid_flush: 1'b1,
      idex_enable: 1'b1, idex_flush: 1'b0, exmem_enable: 1'b1,
      exmem_flush: 1'b0, memwb_enable: 1'b1, memwb_flush: 1'b0};

   // A flush only takes effect when its register is also enabled.
   function automatic logic flush_event(input pipe_ctrl_t c);
      return (c.ifid_enable & c.ifid_flush) | (c.idex_enable & c.idex_flush);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in ID/EX and the instruction in ID.
//   ex_dREN     : ID/EX holds a load
//   ex_rt       : destination register of that load
//   id_rs/id_rt : source registers of the instruction in ID
//   id_uses_rt  : ID instruction actually reads rt
//   load_use    : stall required (register 0 never creates a hazard)
module hazard_detect
   import cpu_types_pkg::*;
(
   input  logic     ex_dREN,
   input  regbits_t ex_rt,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   input  logic     id_uses_rt,
   output logic     load_use
);

   logic rs_match;
   logic rt_match;

   always_comb begin
      rs_match = (ex_rt == id_rs);
      rt_match = id_uses_rt & (ex_rt == id_rt);
      load_use = ex_dREN & (ex_rt != '0) & (rs_match | rt_match);
   end

endmodule

// File: rtl/pipeline_controller.sv
// Stall / flush controller for the 5-stage pipeline.
//   clk, n_rst                : clock, async active-low reset
//   ihit, dhit                : fetch / data access completes this cycle
//   mem_dREN, mem_dWEN        : EX/MEM holds a load / store
//   ex_dREN, ex_rt            : ID/EX load flag and destination
//   id_rs, id_rt, id_uses_rt  : ID source registers
//   branch_taken, jump        : control-flow redirects
//   wb_halt                   : halt instruction reached WB
//   pc_enable, *_enable/*_flush : PC and pipeline register control
//   halted                    : sticky halt flag
//   stall_cycles, flush_count : performance counters
//
// state   | meaning
// RUN     | normal operation, hazard priority applies
// MEMWAIT | data access outstanding, pipeline frozen until dhit
// HALTED  | halt retired; everything frozen until reset
module pipeline_controller
   import cpu_types_pkg::*;
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        mem_dREN,
   input  logic        mem_dWEN,
   input  logic        ex_dREN,
   input  regbits_t    ex_rt,
   input  regbits_t    id_rs,
   input  regbits_t    id_rt,
   input  logic        id_uses_rt,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic        wb_halt,
   output logic        pc_enable,
   output logic        ifid_enable,
   output logic        ifid_flush,
   output logic        idex_enable,
   output logic        idex_flush,
   output logic        exmem_enable,
   output logic        exmem_flush,
   output logic        memwb_enable,
   output logic        memwb_flush,
   output logic        halted,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   pipe_ctrl_state_t state_q;
   pipe_ctrl_state_t state_d;
   pipe_ctrl_t       ctrl;
   logic             load_use;
   logic             mem_pending;
   logic             mem_stall;

   hazard_detect u_hazard_detect (
      .ex_dREN    (ex_dREN),
      .ex_rt      (ex_rt),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_uses_rt (id_uses_rt),
      .load_use   (load_use)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      ctrl        = CTRL_ADVANCE;
      state_d     = state_q;
      mem_pending = mem_dREN | mem_dWEN;
      // In MEMWAIT the stall holds until dhit even if the access flags drop;
      // the dhit cycle itself lets the pipeline advance.
      mem_stall   = ((state_q == MEMWAIT) | mem_pending) & ~dhit;

      case (state_q)
         HALTED: begin
            ctrl = '0;
         end
         default: begin
            if (mem_stall) begin
               ctrl = CTRL_MEMSTALL;
            end else if (branch_taken) begin
               ctrl = CTRL_BRANCH;
            end else if (load_use) begin
               ctrl = CTRL_LOADUSE;
            end else if (jump) begin
               ctrl = CTRL_JUMP;
            end else if (!ihit) begin
               ctrl = CTRL_NOFETCH;
            end else begin
               ctrl = CTRL_ADVANCE;
            end
         end
      endcase

      // Halt wins over any pending memory completion in the same cycle.
      if (wb_halt || state_q == HALTED) begin
         state_d = HALTED;
      end else begin
         case (state_q)
            RUN:     if (mem_pending && !dhit) state_d = MEMWAIT;
            MEMWAIT: if (dhit) state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else if (state_q != HALTED) begin
         if (!ctrl.pc_enable) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (flush_event(ctrl)) begin
            flush_count <= flush_count + 32'd1;
         end
      end
   end

   assign pc_enable    = ctrl.pc_enable;
   assign ifid_enable  = ctrl.ifid_enable;
   assign ifid_flush   = ctrl.ifid_flush;
   assign idex_enable  = ctrl.idex_enable;
   assign idex_flush   = ctrl.idex_flush;
   assign exmem_enable = ctrl.exmem_enable;
   assign exmem_flush  = ctrl.exmem_flush;
   assign memwb_enable = ctrl.memwb_enable;
   assign memwb_flush  = ctrl.memwb_flush;
   assign halted       = (state_q == HALTED);

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with an expectation queue.
// Control vector order: {pc, ifid_en, ifid_fl, idex_en, idex_fl,
//                        exmem_en, exmem_fl, memwb_en, memwb_fl}
module tb_pipeline_controller;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
   logic [4:0]  ex_rt, id_rs, id_rt;
   logic        id_uses_rt, branch_taken, jump, wb_halt;
   logic        pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
   logic        exmem_enable, exmem_flush, memwb_enable, memwb_flush;
   logic        halted;
   logic [31:0] stall_cycles, flush_count;

   localparam logic [8:0] V_ADV  = 9'b1_1010_1010;
   localparam logic [8:0] V_MEM  = 9'b0_0000_0011;
   localparam logic [8:0] V_BR   = 9'b1_1111_1010;
   localparam logic [8:0] V_LU   = 9'b0_0011_1010;
   localparam logic [8:0] V_JMP  = 9'b1_1110_1010;
   localparam logic [8:0] V_NOF  = 9'b0_1110_1010;
   localparam logic [8:0] V_HALT = 9'b0_0000_0000;

   typedef struct packed {
      logic       ihit;
      logic       dhit;
      logic       mem_dREN;
      logic       mem_dWEN;
      logic       ex_dREN;
      logic [4:0] ex_rt;
      logic [4:0] id_rs;
      logic [4:0] id_rt;
      logic       id_uses_rt;
      logic       branch_taken;
      logic       jump;
      logic       wb_halt;
   } stim_t;

   typedef struct packed {
      logic [8:0]  ctrl;
      logic        halted;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    tests = 0;
   int    fails = 0;
   stim_t s;

   pipeline_controller dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .ihit         (ihit),
      .dhit         (dhit),
      .mem_dREN     (mem_dREN),
      .mem_dWEN     (mem_dWEN),
      .ex_dREN      (ex_dREN),
      .ex_rt        (ex_rt),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_uses_rt   (id_uses_rt),
      .branch_taken (branch_taken),
      .jump         (jump),
      .wb_halt      (wb_halt),
      .pc_enable    (pc_enable),
      .ifid_enable  (ifid_enable),
      .ifid_flush   (ifid_flush),
      .idex_enable  (idex_enable),
      .idex_flush   (idex_flush),
      .exmem_enable (exmem_enable),
      .exmem_flush  (exmem_flush),
      .memwb_enable (memwb_enable),
      .memwb_flush  (memwb_flush),
      .halted       (halted),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t r;
      r      = '0;
      r.ihit = 1'b1;
      return r;
   endfunction

   task automatic apply(input stim_t x);
      ihit         = x.ihit;
      dhit         = x.dhit;
      mem_dREN     = x.mem_dREN;
      mem_dWEN     = x.mem_dWEN;
      ex_dREN      = x.ex_dREN;
      ex_rt        = x.ex_rt;
      id_rs        = x.id_rs;
      id_rt        = x.id_rt;
      id_uses_rt   = x.id_uses_rt;
      branch_taken = x.branch_taken;
      jump         = x.jump;
      wb_halt      = x.wb_halt;
   endtask

   task automatic expect_now(input string tag, input logic [8:0] c, input logic h,
                             input logic [31:0] sc, input logic [31:0] fc);
      exp_t e;
      e.ctrl   = c;
      e.halted = h;
      e.stall  = sc;
      e.flush  = fc;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic check();
      exp_t       e;
      string      tag;
      logic [8:0] obs;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard observed=empty expected=entry");
         return;
      end
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      obs = {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush,
             exmem_enable, exmem_flush, memwb_enable, memwb_flush};
      tests++;
      assert (obs === e.ctrl) else begin
         fails++;
         $error("FAIL %s ctrl observed=%b expected=%b", tag, obs, e.ctrl);
      end
      tests++;
      assert (halted === e.halted) else begin
         fails++;
         $error("FAIL %s halted observed=%b expected=%b", tag, halted, e.halted);
      end
      tests++;
      assert (stall_cycles === e.stall) else begin
         fails++;
         $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, stall_cycles, e.stall);
      end
      tests++;
      assert (flush_count === e.flush) else begin
         fails++;
         $error("FAIL %s flush_count observed=%0d expected=%0d", tag, flush_count, e.flush);
      end
   endtask

   // Counters are compared at the negedge of the step, so they reflect
   // everything retired by earlier steps, not the current one.
   task automatic step(input stim_t x, input string tag, input logic [8:0] c,
                       input logic h, input logic [31:0] sc, input logic [31:0] fc);
      apply(x);
      expect_now(tag, c, h, sc, fc);
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst = 1'b0;
      apply(idle());
      expect_now("rst_idle", V_ADV, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check();
      s = idle(); s.mem_dREN = 1'b1;
      apply(s);
      expect_now("rst_memrun", V_MEM, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
      n_rst = 1'b1;

      step(idle(), "idle", V_ADV, 1'b0, 32'd0, 32'd0);

      s = idle(); s.ex_dREN = 1'b1; s.ex_rt = 5'd8; s.id_rs = 5'd8;
      step(s, "loaduse_rs", V_LU, 1'b0, 32'd0, 32'd0);
      step(idle(), "after_lu", V_ADV, 1'b0, 32'd1, 32'd1);

      s = idle(); s.ex_dREN = 1'b1; s.ex_rt = 5'd0; s.id_rs = 5'd0;
      step(s, "r0_nohaz", V_ADV, 1'b0, 32'd1, 32'd1);

      s = idle(); s.ex_dREN = 1'b1; s.ex_rt = 5'd5; s.id_rs = 5'd3; s.id_rt = 5'd5;
      step(s, "rt_unused", V_ADV, 1'b0, 32'd1, 32'd1);
      s.id_uses_rt = 1'b1;
      step(s, "loaduse_rt", V_LU, 1'b0, 32'd1, 32'd1);

      s = idle(); s.jump = 1'b1;
      step(s, "jump", V_JMP, 1'b0, 32'd2, 32'd2);

      s = idle(); s.ihit = 1'b0;
      step(s, "no_ihit", V_NOF, 1'b0, 32'd2, 32'd3);

      s = idle(); s.mem_dREN = 1'b1;
      step(s, "mw_1", V_MEM, 1'b0, 32'd3, 32'd4);
      s = idle();
      step(s, "mw_2_state", V_MEM, 1'b0, 32'd4, 32'd4);
      s = idle(); s.mem_dREN = 1'b1;
      step(s, "mw_3", V_MEM, 1'b0, 32'd5, 32'd4);
      s.dhit = 1'b1;
      step(s, "mw_dhit", V_ADV, 1'b0, 32'd6, 32'd4);
      step(idle(), "mw_back_run", V_ADV, 1'b0, 32'd6, 32'd4);

      s = idle(); s.branch_taken = 1'b1; s.ex_dREN = 1'b1; s.ex_rt = 5'd8; s.id_rs = 5'd8;
      step(s, "branch_vs_lu", V_BR, 1'b0, 32'd6, 32'd4);

      s = idle(); s.mem_dWEN = 1'b1; s.dhit = 1'b1;
      step(s, "store_hit", V_ADV, 1'b0, 32'd6, 32'd5);

      s = idle(); s.mem_dWEN = 1'b1; s.branch_taken = 1'b1;
      step(s, "mem_vs_branch", V_MEM, 1'b0, 32'd6, 32'd5);

      s = idle(); s.mem_dWEN = 1'b1; s.dhit = 1'b1; s.wb_halt = 1'b1;
      step(s, "halt_dhit", V_ADV, 1'b0, 32'd7, 32'd5);

      s = idle(); s.ihit = 1'b0; s.ex_dREN = 1'b1; s.ex_rt = 5'd8; s.id_rs = 5'd8;
      step(s, "halted_1", V_HALT, 1'b1, 32'd7, 32'd5);
      s = idle(); s.mem_dREN = 1'b1; s.jump = 1'b1;
      step(s, "halted_2", V_HALT, 1'b1, 32'd7, 32'd5);

      n_rst = 1'b0;
      apply(idle());
      #1;
      expect_now("async_rst", V_ADV, 1'b0, 32'd0, 32'd0);
      check();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      step(idle(), "post_rst", V_ADV, 1'b0, 32'd0, 32'd0);
      s = idle(); s.ihit = 1'b0;
      step(s, "post_rst_nof", V_NOF, 1'b0, 32'd0, 32'd0);
      step(idle(), "post_rst_cnt", V_ADV, 1'b0, 32'd1, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock, with all state updating on the rising edge.
REQ-002 SHALL have port n_rst, input, 1, the reset, which is asynchronous and active-low.
REQ-003 SHALL have port ihit, input, 1, meaning the instruction fetch completes this cycle.
REQ-004 SHALL have port dhit, input, 1, meaning the MEM-stage data access completes this cycle.
REQ-005 SHALL have ports mem_dREN and mem_dWEN, input, 1 each, meaning the EX/MEM stage holds a load or store.
REQ-006 SHALL have ports ex_dREN, input, 1, and ex_rt, input, 5, giving the ID/EX load flag and its destination register.
REQ-007 SHALL have ports id_rs and id_rt, input, 5 each, and id_uses_rt, input, 1, giving the source registers of the instruction in ID.
REQ-008 SHALL have ports branch_taken, input, 1 (branch resolved taken in EX), jump, input, 1 (J/JAL/JR decoded in ID), and wb_halt, input, 1 (halt reached WB).
REQ-009 SHALL have ports pc_enable, ifid_enable/ifid_flush, idex_enable/idex_flush, exmem_enable/exmem_flush and memwb_enable/memwb_flush, output, 1 each, driving the PC and pipeline registers, where enable=0 holds a register and flush acts only with enable=1.
REQ-010 SHALL have port halted, output, 1, sticky halt indication.
REQ-011 SHALL have ports stall_cycles and flush_count, output, 32 each, performance counters.

Function
REQ-012 SHALL implement an FSM with states RUN, MEMWAIT and HALTED.
REQ-013 SHALL transition RUN->MEMWAIT when (mem_dREN|mem_dWEN)&!dhit, MEMWAIT->RUN on dhit, and any state->HALTED on wb_halt, with HALTED having highest priority and being exited only by reset.
REQ-014 In HALTED, SHALL hold every enable and flush at 0, pc_enable=0 and halted=1.
REQ-015 In MEMWAIT, or in RUN with a pending data access and !dhit, SHALL hold PC, IF/ID, ID/EX and EX/MEM (enable=0), and SHALL set memwb_enable=1 with memwb_flush=1 to insert a bubble.
REQ-016 Otherwise, on branch_taken, SHALL assert pc_enable=1, flush IF/ID and ID/EX (enable=1, flush=1), and advance EX/MEM and MEM/WB.
REQ-017 Otherwise, on load-use, SHALL set pc_enable=0 and ifid_enable=0, flush ID/EX, and advance EX/MEM and MEM/WB.
REQ-018 SHALL define load-use as ex_dREN & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
REQ-019 Otherwise, on jump, SHALL set pc_enable=1, flush IF/ID, and advance all other stages.
REQ-020 Otherwise, on !ihit, SHALL set pc_enable=0, flush IF/ID, and advance all other stages.
REQ-021 Otherwise, SHALL enable all registers with no flush and set pc_enable=1.
REQ-022 SHALL compute all outputs combinationally from the current state and inputs within the same cycle, with zero-cycle latency.
REQ-023 SHALL increment stall_cycles in each non-HALTED cycle with pc_enable=0, wrapping modulo 2^32.
REQ-024 SHALL increment flush_count by 1 per cycle in which any of ifid_flush or idex_flush is asserted with its enable, wrapping modulo 2^32.
REQ-025 SHALL freeze both counters in HALTED.
REQ-026 When wb_halt and a pending dhit occur together, SHALL give HALTED priority, with outputs in that cycle following the REQ-015 to REQ-021 rules and halted=1 from the next cycle.

Reset
REQ-027 While n_rst=0, SHALL asynchronously force state=RUN, halted=0 and both counters to 0.
REQ-028 During reset, enable and flush outputs SHALL follow RUN combinational rules, so a mid-MEMWAIT reset resumes in RUN.

Structure
REQ-029 SHALL place the state enum pipe_ctrl_state_t in cpu_types_pkg and reuse the existing 5-bit register-index type.
REQ-030 SHALL implement load-use comparison in a combinational sub-module named hazard_detect.

Verification
REQ-031 SHALL verify load-use: ex_dREN=1, ex_rt=8, id_rs=8 -> pc_enable=0, ifid_enable=0, idex_flush=1, stall_cycles +1.
REQ-032 SHALL verify that ex_rt=0 with id_rs=0 and ex_dREN=1 -> no stall and all enables=1.
REQ-033 SHALL verify that mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> MEMWAIT for 3 cycles, memwb_flush=1, then RUN, stall_cycles=3.
REQ-034 SHALL verify branch_taken=1 together with load-use -> branch wins, ifid_flush=idex_flush=1, pc_enable=1, flush_count +1.
REQ-035 SHALL verify wb_halt=1 -> halted=1 next cycle, all enables 0, counters frozen, and n_rst low clears all.
